// File: rtl/microcode_pkg.sv
// Shared types and sizes for the horizontal microcode store and its boot loader.
package microcode_pkg;

  localparam int unsigned UCODE_W     = 19;
  localparam int unsigned UCODE_DEPTH = 64;
  localparam int unsigned UCODE_AW    = 6;
  localparam int unsigned UCODE_BYTES = 3;
  localparam int unsigned BYTE_W      = 8;

  typedef logic [UCODE_W-1:0]  ucode_word_t;
  typedef logic [UCODE_AW-1:0] ucode_addr_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } loader_state_e;

  // One microcode write-port transaction.
  typedef struct packed {
    logic        we;
    ucode_addr_t addr;
    ucode_word_t data;
  } mc_wr_t;

endpackage

// File: rtl/microcode_word_assembler.sv
// Packs little-endian byte triples into one control word; flags nonzero reserved bits.
module microcode_word_assembler
  import microcode_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_done_c,
  output logic              rsvd_err_c,
  output ucode_word_t       word_c
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned LOW_W = 2 * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UCODE_BYTES - 1);

  logic [IDX_W-1:0] idx_q;
  logic [LOW_W-1:0] pack_q;

  // Byte index and low two bytes of the word under construction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      pack_q <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
    end else if (byte_valid_i) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      case (idx_q)
        IDX_W'(0): pack_q[BYTE_W-1:0]     <= byte_i;
        IDX_W'(1): pack_q[LOW_W-1:BYTE_W] <= byte_i;
        default:   pack_q                 <= pack_q;
      endcase
    end
  end

  // The third byte completes the word in the same cycle it is accepted.
  assign word_done_c = byte_valid_i && (idx_q == LAST_IDX);
  assign rsvd_err_c  = word_done_c && (byte_i[BYTE_W-1:UCODE_W-LOW_W] != '0);
  assign word_c      = {byte_i[UCODE_W-LOW_W-1:0], pack_q};

endmodule

// File: rtl/microcode_loader.sv
// Boot-time microcode loader: streams bytes into the ucode store and verifies a trailing checksum.
module microcode_loader
  import microcode_pkg::*;
#(
  parameter int unsigned NUM_WORDS = UCODE_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [BYTE_W-1:0]  s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic               mc_we_o,
  output logic [UCODE_AW-1:0] mc_addr_o,
  output logic [UCODE_W-1:0] mc_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic               core_hold_o
);

  localparam int unsigned CNT_W = UCODE_AW + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  waddr_q, waddr_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  mc_wr_t            wr_q, wr_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              hold_q, hold_d;

  logic        xfer;
  logic        start_ok;
  logic        word_done;
  logic        rsvd_err;
  ucode_word_t word;

  assign xfer     = s_valid_i && ready_q;
  assign start_ok = start_i && (state_q inside {LD_IDLE, LD_DONE, LD_ERROR});

  microcode_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (start_ok),
    .byte_valid_i (xfer && (state_q == LD_LOAD)),
    .byte_i       (s_data_i),
    .word_done_c  (word_done),
    .rsvd_err_c   (rsvd_err),
    .word_c       (word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LD_IDLE;
      waddr_q <= '0;
      csum_q  <= '0;
      wr_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      csum_q  <= csum_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, write register and status flags; flags are decoded from the next state.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    csum_d  = csum_q;
    wr_d    = wr_q;
    wr_d.we = 1'b0;

    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start_ok) begin
          state_d = LD_LOAD;
          waddr_d = '0;
          csum_d  = '0;
        end
      end
      LD_LOAD: begin
        if (xfer) begin
          csum_d = csum_q + s_data_i;
          if (word_done) begin
            if (rsvd_err) begin
              state_d = LD_ERROR;
            end else begin
              wr_d.we   = 1'b1;
              wr_d.addr = waddr_q[UCODE_AW-1:0];
              wr_d.data = word;
              waddr_d   = waddr_q + CNT_W'(1);
              if (waddr_q == LAST_WORD) state_d = LD_CHECK;
            end
          end
        end
      end
      LD_CHECK: begin
        if (xfer) begin
          csum_d  = csum_q + s_data_i;
          state_d = (csum_d == '0) ? LD_DONE : LD_ERROR;
        end
      end
      default: state_d = LD_IDLE;
    endcase

    ready_d = (state_d == LD_LOAD) || (state_d == LD_CHECK);
    busy_d  = ready_d;
    done_d  = (state_d == LD_DONE);
    error_d = (state_d == LD_ERROR);
    hold_d  = !done_d;
  end

  assign s_ready_o   = ready_q;
  assign mc_we_o     = wr_q.we;
  assign mc_addr_o   = wr_q.addr;
  assign mc_data_o   = wr_q.data;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign core_hold_o = hold_q;

endmodule
